// File: rtl/dac_sample_sequencer_pkg.sv
// Shared definitions for the DAC sample sequencer: FSM encoding and default
// DAC command/idle codes.
package dac_sample_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_ISSUE    = 2'd2
  } seq_state_t;

  localparam logic [7:0]  DEFAULT_CMD_BYTE  = 8'h31;
  localparam logic [15:0] DEFAULT_IDLE_CODE = 16'h8000;
  localparam int          SAMPLE_W          = 16;

endpackage

// File: rtl/dac_sample_sequencer_fifo.sv
// Power-of-two sample FIFO; head is read combinationally so a pop and the
// corresponding data capture happen on the same edge.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == FULL_LEVEL);
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_reg;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces FIFO samples out to a DAC SPI stage at a fixed tick rate, repeating
// the last sample on underrun and flagging late ticks.
module dac_sample_sequencer
  import dac_sample_sequencer_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          RATE_DIV  = 480,
  parameter logic [7:0]  CMD_BYTE  = DEFAULT_CMD_BYTE,
  parameter logic [15:0] IDLE_CODE = DEFAULT_IDLE_CODE
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Enable,
  input  logic [SAMPLE_W-1:0]        i_Sample,
  input  logic                       i_Valid,
  output logic                       o_Ready,
  input  logic                       i_DAC_Ready,
  output logic [23:0]                o_DAC_Data,
  output logic                       o_DAC_Send,
  output logic [$clog2(DEPTH):0]     o_Level,
  output logic                       o_Underrun,
  output logic                       o_Late,
  input  logic                       i_Clear_Flags
);

  localparam int             CW       = $clog2(RATE_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0]       rate_cnt_reg;
  logic                tick;
  seq_state_t          state_reg;
  seq_state_t          state_next;
  logic                late_set;
  logic                issue_load;
  logic                under_set;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [23:0]         dac_data_reg;
  logic [SAMPLE_W-1:0] last_sample_reg;
  logic                underrun_reg;
  logic                late_reg;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n)                   rate_cnt_reg <= '0;
    else if (!i_Enable)               rate_cnt_reg <= '0;
    else if (rate_cnt_reg == CNT_LAST) rate_cnt_reg <= '0;
    else                              rate_cnt_reg <= rate_cnt_reg + 1'b1;
  end

  assign tick = i_Enable && (rate_cnt_reg == CNT_LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // A tick seen while already waiting is absorbed: one send per pending request.
  always_comb begin
    state_next = state_reg;
    late_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick) state_next = i_DAC_Ready ? ST_ISSUE : ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (!i_Enable)        state_next = ST_IDLE;
        else if (i_DAC_Ready) state_next = ST_ISSUE;
        else if (tick)        late_set   = 1'b1;
      end
      ST_ISSUE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign issue_load = (state_next == ST_ISSUE);
  assign under_set  = issue_load && fifo_empty;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .push      (i_Valid),
    .push_data (i_Sample),
    .pop       (issue_load),
    .head      (fifo_head),
    .level     (o_Level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      dac_data_reg    <= {CMD_BYTE, IDLE_CODE};
      last_sample_reg <= IDLE_CODE;
    end else if (issue_load) begin
      if (!fifo_empty) begin
        dac_data_reg    <= {CMD_BYTE, fifo_head};
        last_sample_reg <= fifo_head;
      end else begin
        dac_data_reg    <= {CMD_BYTE, last_sample_reg};
      end
    end
  end

  // Setting events take priority over a coincident clear.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      underrun_reg <= 1'b0;
      late_reg     <= 1'b0;
    end else begin
      if (under_set)          underrun_reg <= 1'b1;
      else if (i_Clear_Flags) underrun_reg <= 1'b0;
      if (late_set)           late_reg     <= 1'b1;
      else if (i_Clear_Flags) late_reg     <= 1'b0;
    end
  end

  assign o_DAC_Send = (state_reg == ST_ISSUE);
  assign o_DAC_Data = dac_data_reg;
  assign o_Ready    = !fifo_full;
  assign o_Underrun = underrun_reg;
  assign o_Late     = late_reg;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Randomised and directed checks of dac_sample_sequencer against a
// queue-based behavioural model (DEPTH=4, RATE_DIV=8).
module tb_dac_sample_sequencer;

  localparam int DEPTH    = 4;
  localparam int RATE_DIV = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        vld   = 1'b0;
  logic        drdy  = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] smp   = '0;
  logic        rdy;
  logic        send;
  logic        under;
  logic        late;
  logic [23:0] ddata;
  logic [2:0]  level;

  always #5 clk = ~clk;

  dac_sample_sequencer #(
    .DEPTH     (DEPTH),
    .RATE_DIV  (RATE_DIV),
    .CMD_BYTE  (8'h31),
    .IDLE_CODE (16'h8000)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Enable      (en),
    .i_Sample      (smp),
    .i_Valid       (vld),
    .o_Ready       (rdy),
    .i_DAC_Ready   (drdy),
    .o_DAC_Data    (ddata),
    .o_DAC_Send    (send),
    .o_Level       (level),
    .o_Underrun    (under),
    .o_Late        (late),
    .i_Clear_Flags (clr)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: sample queue, tick counter, request bookkeeping.
  int          m_cnt;
  bit          m_pending;
  bit          m_sending;
  bit          m_under;
  bit          m_late;
  logic [15:0] m_last;
  logic [15:0] m_data;
  logic [15:0] m_q[$];

  logic [23:0] sent_data[$];
  int          sent_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_pending = 0;
    m_sending = 0;
    m_under   = 0;
    m_late    = 0;
    m_last    = 16'h8000;
    m_data    = 16'h8000;
    m_q.delete();
  endtask

  task automatic compare_all();
    check_val("send",     32'(send),  32'(m_sending));
    check_val("data",     32'(ddata), {8'h0, 8'h31, m_data});
    check_val("level",    32'(level), 32'(m_q.size()));
    check_val("ready",    32'(rdy),   32'(m_q.size() != DEPTH));
    check_val("underrun", 32'(under), 32'(m_under));
    check_val("late",     32'(late),  32'(m_late));
  endtask

  task automatic step();
    bit tick;
    bit start;
    bit late_set;
    bit under_set;
    int size_pre;
    @(posedge clk);
    cyc++;
    tick      = en && (m_cnt == RATE_DIV - 1);
    size_pre  = m_q.size();
    start     = 0;
    late_set  = 0;
    under_set = 0;
    if (!m_sending) begin
      if (m_pending) begin
        if (!en) m_pending = 0;
        else if (drdy) begin
          start     = 1;
          m_pending = 0;
        end else if (tick) late_set = 1;
      end else if (tick) begin
        if (drdy) start = 1;
        else      m_pending = 1;
      end
    end
    if (start) begin
      if (size_pre > 0) begin
        m_data = m_q.pop_front();
        m_last = m_data;
      end else begin
        m_data    = m_last;
        under_set = 1;
      end
    end
    if (vld && size_pre < DEPTH) m_q.push_back(smp);
    m_cnt     = en ? (m_cnt + 1) % RATE_DIV : 0;
    m_sending = start;
    m_under   = under_set ? 1'b1 : (clr ? 1'b0 : m_under);
    m_late    = late_set  ? 1'b1 : (clr ? 1'b0 : m_late);
    #1;
    if (send) begin
      sent_data.push_back(ddata);
      sent_cyc.push_back(cyc);
      $display("send cyc=%0d data=%h level=%0d", cyc, ddata, level);
    end
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after a rising edge; reset is asserted asynchronously.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_val("rst_send",  32'(send),  32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_ready", 32'(rdy),   32'd1);
    check_val("rst_data",  32'(ddata), 32'h0031_8000);
    check_val("rst_under", 32'(under), 32'd0);
    check_val("rst_late",  32'(late),  32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (i < sent_data.size()) ? 32'(sent_data[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < sent_cyc.size()) ? sent_cyc[i] : -1;
  endfunction

  initial begin
    int start_cyc;
    int n;
    int lvl_before;
    bit en_phase;

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Three samples out in order, 8 cycles apart, then an underrun repeat.
    drdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      vld = 1'b1;
      smp = 16'(i * 16'h0100);
      step();
    end
    vld = 1'b0;
    sent_data.delete();
    sent_cyc.delete();
    start_cyc = cyc;
    en = 1'b1;
    run(34);
    check_val("seq_s0", sent_at(0), 32'h0031_0100);
    check_val("seq_s1", sent_at(1), 32'h0031_0200);
    check_val("seq_s2", sent_at(2), 32'h0031_0300);
    check_val("seq_s3", sent_at(3), 32'h0031_0300);
    check_val("seq_lat", 32'(cyc_at(0)), 32'(start_cyc + RATE_DIV));
    check_val("seq_gap1", 32'(cyc_at(1) - cyc_at(0)), 32'(RATE_DIV));
    check_val("seq_gap2", 32'(cyc_at(2) - cyc_at(1)), 32'(RATE_DIV));
    check_val("seq_under", 32'(under), 32'd1);

    // Empty FIFO straight after reset repeats the idle code.
    en = 1'b0;
    do_reset();
    sent_data.delete();
    en = 1'b1;
    run(10);
    check_val("idle_first", sent_at(0), 32'h0031_8000);

    // Ready held low three cycles after a tick delays the send.
    en = 1'b0;
    do_reset();
    drdy = 1'b0;
    vld  = 1'b1;
    smp  = 16'h1111;
    step();
    smp  = 16'h2222;
    step();
    vld  = 1'b0;
    en   = 1'b1;
    n = 0;
    while (!m_pending && n < 20) begin
      step();
      n++;
    end
    check_val("wait_pending1", 32'(m_pending), 32'd1);
    run(2);
    drdy = 1'b1;
    step();
    check_val("rdy_delay_send", 32'(send), 32'd1);
    check_val("rdy_delay_data", 32'(ddata), 32'h0031_1111);

    // Ready low across a second tick: late flag and a single send.
    drdy = 1'b0;
    n = 0;
    while (!m_pending && n < 20) begin
      step();
      n++;
    end
    check_val("wait_pending2", 32'(m_pending), 32'd1);
    sent_data.delete();
    run(10);
    check_val("late_flag", 32'(late), 32'd1);
    drdy = 1'b1;
    run(4);
    check_val("late_one_send", 32'(sent_data.size()), 32'd1);

    // Five back-to-back writes: four accepted.
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1;
      smp = 16'(16'hA000 + i);
      step();
      check_val("full_ready", 32'(rdy), (i < DEPTH - 1) ? 32'd1 : 32'd0);
    end
    vld = 1'b0;
    check_val("full_level", 32'(level), 32'd4);

    // Write coincident with a pop leaves the level unchanged.
    en = 1'b1;
    run(RATE_DIV + 1);
    n = 0;
    while (m_cnt != RATE_DIV - 1 && n < 20) begin
      step();
      n++;
    end
    lvl_before = m_q.size();
    vld = 1'b1;
    smp = 16'h5A5A;
    step();
    vld = 1'b0;
    check_val("pop_push_send", 32'(send), 32'd1);
    check_val("pop_push_level", 32'(level), 32'(lvl_before));

    // Clear coincident with an underrun: the set wins.
    en = 1'b0;
    do_reset();
    en = 1'b1;
    n = 0;
    while (m_cnt != RATE_DIV - 1 && n < 20) begin
      step();
      n++;
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("clr_vs_set", 32'(under), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("clr_alone", 32'(under), 32'd0);

    // Reset during ISSUE aborts the strobe and empties the FIFO.
    en = 1'b0;
    do_reset();
    vld = 1'b1;
    smp = 16'h0BEE;
    run(2);
    vld = 1'b0;
    en  = 1'b1;
    n = 0;
    while (!m_sending && n < 20) begin
      step();
      n++;
    end
    check_val("wait_issue", 32'(send), 32'd1);
    do_reset();
    en = 1'b0;
    run(3);

    // Randomised traffic against the model.
    en_phase = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) en_phase = !en_phase;
      en   = en_phase;
      drdy = ($urandom_range(0, 3) != 0);
      vld  = ($urandom_range(0, 99) < (((i / 250) % 2) ? 30 : 8));
      smp  = 16'($urandom);
      clr  = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 1'b0;
    vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
